// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide, little-endian instruction
// memory write port, holding the core in busy while a program is loading.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 256,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WR0,
        WR1,
        WR2,
        WR3,
        FIN
    } state_t;

    state_t      state;
    logic [63:0] ptr;
    logic [31:0] word_buf;
    logic        last_buf;
    logic        word_fits;

    // A word is only taken into the write sequence if all four bytes land in memory.
    assign word_fits = (ptr + 64'd4) <= END_ADDR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= BASE_ADDR;
            word_buf     <= 32'd0;
            last_buf     <= 1'b0;
            word_ready   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state        <= ACCEPT;
                        ptr          <= BASE_ADDR;
                        words_loaded <= 16'd0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        busy         <= 1'b1;
                        word_ready   <= 1'b1;
                    end
                end

                ACCEPT: begin
                    if (word_valid && word_ready) begin
                        word_ready <= 1'b0;
                        if (word_fits) begin
                            // Byte 0 is presented on the cycle right after the handshake.
                            word_buf  <= word_data;
                            last_buf  <= word_last;
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr;
                            mem_wdata <= word_data[7:0];
                            state     <= WR0;
                        end else begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end
                    end
                end

                WR0: begin
                    mem_addr  <= ptr + 64'd1;
                    mem_wdata <= word_buf[15:8];
                    state     <= WR1;
                end

                WR1: begin
                    mem_addr  <= ptr + 64'd2;
                    mem_wdata <= word_buf[23:16];
                    state     <= WR2;
                end

                WR2: begin
                    mem_addr  <= ptr + 64'd3;
                    mem_wdata <= word_buf[31:24];
                    state     <= WR3;
                end

                WR3: begin
                    mem_we <= 1'b0;
                    ptr    <= ptr + 64'd4;
                    if (words_loaded != 16'hFFFF) begin
                        words_loaded <= words_loaded + 16'd1;
                    end
                    if (last_buf) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        word_ready <= 1'b1;
                        state      <= ACCEPT;
                    end
                end

                default: begin
                    state      <= IDLE;
                    word_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
